// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: owner encodings and sizing helper shared by the arbiter files
package mem_arbiter_pkg;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;
    function automatic int unsigned streak_width(input int unsigned max_streak);
        return (max_streak < 2) ? 1 : $clog2(max_streak + 1);
    endfunction
endpackage

// File: rtl/mem_arbiter_streak_counter.sv
// arb_streak_counter: counts consecutive contended DM grants and flags when IF must win
module arb_streak_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DM_STREAK = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_if_o
);
    localparam int unsigned CW = streak_width(MAX_DM_STREAK);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_DM_STREAK);
    logic [CW-1:0] streak_q, streak_d;
    // next count: clear wins, otherwise saturating increment on a contended DM grant
    always_comb begin
        streak_d = clr_i ? '0 : (inc_i && streak_q != MAX_C) ? streak_q + 1'b1 : streak_q;
    end
    // streak register
    always_ff @(posedge clk_i) begin
        if (rst_i) streak_q <= '0;
        else       streak_q <= streak_d;
    end
    assign force_if_o = (MAX_DM_STREAK != 0) && (streak_q == MAX_C);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word RAM between fetch (IF) and load/store (DM)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_SIZE     = 10,
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned MAX_DM_STREAK = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 if_req_i,
    input  logic [WORD_SIZE-1:0] if_addr_i,
    output logic                 if_gnt_o,
    output logic                 if_rvalid_o,
    output logic [WORD_SIZE-1:0] if_rdata_o,
    output logic                 stall_o,
    input  logic                 dm_req_i,
    input  logic                 dm_we_i,
    input  logic [WORD_SIZE-1:0] dm_addr_i,
    input  logic [WORD_SIZE-1:0] dm_wdata_i,
    output logic                 dm_gnt_o,
    output logic                 dm_rvalid_o,
    output logic [WORD_SIZE-1:0] dm_rdata_o,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic [WORD_SIZE-1:0] mem_rdata_i
);
    logic       force_if;
    logic [1:0] owner_q, owner_d;
    logic       unused_addr_hi;
    assign unused_addr_hi = ^{if_addr_i[WORD_SIZE-1:ADDR_SIZE], dm_addr_i[WORD_SIZE-1:ADDR_SIZE]};
    arb_streak_counter #(.MAX_DM_STREAK(MAX_DM_STREAK)) u_streak (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (dm_gnt_o & if_req_i),
        .clr_i     (if_gnt_o | ~if_req_i),
        .force_if_o(force_if)
    );
    // grant selection and memory port drive; DM wins contention unless the streak forces IF
    always_comb begin
        if_gnt_o    = ~rst_i & if_req_i & (~dm_req_i | force_if);
        dm_gnt_o    = ~rst_i & dm_req_i & ~if_gnt_o;
        stall_o     = ~rst_i & if_req_i & ~if_gnt_o;
        mem_en_o    = if_gnt_o | dm_gnt_o;
        mem_we_o    = dm_gnt_o & dm_we_i;
        mem_addr_o  = dm_gnt_o ? dm_addr_i[ADDR_SIZE-1:0] : if_gnt_o ? if_addr_i[ADDR_SIZE-1:0] : '0;
        mem_wdata_o = dm_gnt_o ? dm_wdata_i : '0;
        owner_d     = if_gnt_o ? OWN_IF : (dm_gnt_o & ~dm_we_i) ? OWN_DM : OWN_NONE;
    end
    // remember who owns the read data returning next cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) owner_q <= OWN_NONE;
        else       owner_q <= owner_d;
    end
    assign if_rvalid_o = ~rst_i & (owner_q == OWN_IF);
    assign dm_rvalid_o = ~rst_i & (owner_q == OWN_DM);
    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;
endmodule
